square_duty_detector: RTL and testbench

- Receive-side counterpart to the duty-selectable square-wave generator.
- Consumes a stream of 16-bit signed samples framed in FRAME_LEN-sample periods, counts high samples per frame, and decodes the duty-select code (0..10, i.e. 0%..100% in 10% steps).
- Sits after the FIR/IIR filter chain or directly on the waveform-generator output for loopback self-check. Reports the per-frame high count, the decoded code, an exact-match flag and a lock indication.

---
 rtl/square_duty_detector.sv | 242 ++++++++++++++++++++++++
 tb/tb_square_duty_detector.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_duty_detector.sv
// ============================================================================
// square_duty_detector
// ----------------------------------------------------------------------------
// Receive-side counterpart of the duty-selectable square-wave generator.
// Samples arrive in frames of FRAME_LEN. Within a frame the block counts the
// samples that lie strictly above LEVEL_TH. It then decodes that count into
// the generator duty code (0..10, i.e. 0%..100% in 10% steps). The block also
// reports whether the count hits the generator's exact threshold for that
// code, and it tracks how many consecutive frames decoded to the same code.
//
// Ports
//   i_clk       clock
//   i_rst       synchronous reset, active-high
//   i_valid     sample strobe; i_data / i_sync only meaningful when high
//   i_data      16-bit signed sample
//   i_sync      frame marker (sample is frame index 0), qualified by i_valid
//   o_valid     one-cycle pulse, frame result valid
//   o_code      decoded duty code 0..10
//   o_high_cnt  high-sample count of the last completed frame
//   o_exact     o_high_cnt equals the generator threshold for o_code
//   o_locked    code has been stable for LOCK_FRAMES complete frames
//   o_err       one-cycle pulse, frame aborted by a sync at a non-zero index
// ============================================================================
module square_duty_detector #(
    parameter int                 FRAME_LEN   = 1024,
    parameter logic signed [15:0] LEVEL_TH    = 16'sh1000,
    parameter int                 LOCK_FRAMES = 2,
    localparam int                CNT_W       = $clog2(FRAME_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [15:0]      i_data,
    input  logic             i_sync,
    output logic             o_valid,
    output logic [3:0]       o_code,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic             o_exact,
    output logic             o_locked,
    output logic             o_err
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int LOCK_W   = 4;
    localparam int NUM_CODE = 10;

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = '1;
    localparam logic [LOCK_W-1:0] LOCK_REQ = LOCK_W'(LOCK_FRAMES);

    // Lowest count that decodes to code k (k = 1..10). The decision point is
    // placed midway between two neighbouring generator thresholds, so a
    // filtered waveform with a few edge samples smeared still decodes
    // correctly.
    function automatic logic [CNT_W-1:0] code_min_cnt(input int k);
        return CNT_W'(((2 * k - 1) * FRAME_LEN) / 20);
    endfunction

    // Exact number of high samples the generator emits for code k.
    function automatic logic [CNT_W-1:0] code_target_cnt(input int k);
        return CNT_W'((k * 10 * FRAME_LEN) / 100);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic {
        ST_SEARCH = 1'b0,   // waiting for the first qualified sync
        ST_RUN    = 1'b1    // framing established, counting samples
    } state_t;

    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [LOCK_W-1:0]  lock_cnt_q,  lock_cnt_d;
    logic [3:0]         prev_code_q, prev_code_d;

    logic               valid_q,     valid_d;
    logic [3:0]         code_q,      code_d;
    logic [CNT_W-1:0]   high_cnt_q,  high_cnt_d;
    logic               exact_q,     exact_d;
    logic               locked_q,    locked_d;
    logic               err_q,       err_d;

    // ------------------------------------------------------------------------
    // Per-sample datapath
    // ------------------------------------------------------------------------
    logic             sample_hi;
    logic [CNT_W-1:0] cnt_inc;
    logic             early_sync;
    logic             frame_last;

    assign sample_hi  = ($signed(i_data) > LEVEL_TH);
    // The count in front of the final sample never exceeds FRAME_LEN-1, so
    // this increment cannot wrap.
    assign cnt_inc    = cnt_q + CNT_W'(sample_hi);
    // A sync at index 0 is an ordinary frame start. A sync at any other index,
    // including the final one, breaks the frame.
    assign early_sync = i_valid && i_sync && (idx_q != '0);
    assign frame_last = (idx_q == IDX_LAST);

    // ------------------------------------------------------------------------
    // Duty-code decode of the count that includes the current sample
    // ------------------------------------------------------------------------
    logic [3:0] dec_code;
    logic       dec_exact;

    always_comb begin
        dec_code = '0;
        for (int k = 1; k <= NUM_CODE; k++) begin
            if (cnt_inc >= code_min_cnt(k)) begin
                dec_code = dec_code + 4'd1;
            end
        end

        dec_exact = 1'b0;
        for (int k = 0; k <= NUM_CODE; k++) begin
            if ((dec_code == 4'(k)) && (cnt_inc == code_target_cnt(k))) begin
                dec_exact = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case
    // statement. Any path that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        lock_cnt_d  = lock_cnt_q;
        prev_code_d = prev_code_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        high_cnt_d  = high_cnt_q;
        exact_d     = exact_q;
        locked_d    = locked_q;

        unique case (state_q)
            ST_SEARCH: begin
                if (i_valid && i_sync) begin
                    // The sync sample is index 0 of the first frame and is
                    // counted like any other sample.
                    state_d = ST_RUN;
                    idx_d   = IDX_W'(1);
                    cnt_d   = CNT_W'(sample_hi);
                end
            end

            ST_RUN: begin
                if (i_valid) begin
                    if (early_sync) begin
                        // Drop the broken frame and restart framing on this
                        // sample. Lock history is discarded with the frame.
                        idx_d      = IDX_W'(1);
                        cnt_d      = CNT_W'(sample_hi);
                        err_d      = 1'b1;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                    end else if (frame_last) begin
                        idx_d       = '0;
                        cnt_d       = '0;
                        valid_d     = 1'b1;
                        high_cnt_d  = cnt_inc;
                        code_d      = dec_code;
                        exact_d     = dec_exact;
                        prev_code_d = dec_code;

                        // A zero lock count marks the first frame after
                        // SEARCH or an abort. That frame starts a new run
                        // regardless of the remembered code.
                        if ((lock_cnt_q == '0) || (dec_code == prev_code_q)) begin
                            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q
                                                                  : lock_cnt_q + 1'b1;
                        end else begin
                            lock_cnt_d = LOCK_W'(1);
                        end
                        locked_d = (lock_cnt_d >= LOCK_REQ);
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = cnt_inc;
                    end
                end
            end

            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its _d value from before the edge, whatever order the
    // statements appear in.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_SEARCH;
            idx_q       <= '0;
            cnt_q       <= '0;
            lock_cnt_q  <= '0;
            prev_code_q <= '0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            high_cnt_q  <= '0;
            exact_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            prev_code_q <= prev_code_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            high_cnt_q  <= high_cnt_d;
            exact_q     <= exact_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_valid    = valid_q;
    assign o_code     = code_q;
    assign o_high_cnt = high_cnt_q;
    assign o_exact    = exact_q;
    assign o_locked   = locked_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_square_duty_detector.sv
// ============================================================================
// tb_square_duty_detector
// ----------------------------------------------------------------------------
// Scoreboard bench. The stimulus side feeds every sample it drives into a
// frame-level reference model. The model collects whole frames and, when a
// frame completes or aborts, pushes the expected response into a queue. A
// separate monitor pops one entry whenever the DUT raises o_valid or o_err
// and compares the fields.
// ============================================================================
module tb_square_duty_detector;

    localparam int FRAME_LEN   = 1024;
    localparam int LEVEL       = 4096;   // 16'sh1000
    localparam int LOCK_FRAMES = 2;
    localparam int HALF_PERIOD = 5;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [15:0] i_data;
    logic        i_sync;
    logic        o_valid;
    logic [3:0]  o_code;
    logic [10:0] o_high_cnt;
    logic        o_exact;
    logic        o_locked;
    logic        o_err;

    square_duty_detector #(
        .FRAME_LEN   (FRAME_LEN),
        .LEVEL_TH    (16'sh1000),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_sync     (i_sync),
        .o_valid    (o_valid),
        .o_code     (o_code),
        .o_high_cnt (o_high_cnt),
        .o_exact    (o_exact),
        .o_locked   (o_locked),
        .o_err      (o_err)
    );

    always #HALF_PERIOD i_clk = ~i_clk;

    // ------------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------------
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard queue
    // ------------------------------------------------------------------------
    typedef struct {
        bit  is_err;
        int  cnt;
        int  code;
        bit  exact;
        bit  locked;
        time t_push;
    } exp_t;

    exp_t exp_q[$];

    // ------------------------------------------------------------------------
    // Reference model: collects whole frames and evaluates them as a set
    // ------------------------------------------------------------------------
    bit          m_run = 1'b0;
    logic [15:0] m_frame[$];
    int          m_lock = 0;
    int          m_prev = 0;

    task automatic model_reset();
        m_run = 1'b0;
        m_frame.delete();
        m_lock = 0;
        m_prev = 0;
    endtask

    task automatic model_frame_done();
        exp_t e;
        int   cnt;
        int   code;
        cnt = 0;
        foreach (m_frame[i]) begin
            if (int'($signed(m_frame[i])) > LEVEL) cnt++;
        end
        code = 0;
        for (int k = 1; k <= 10; k++) begin
            if (cnt >= ((2 * k - 1) * FRAME_LEN) / 20) code++;
        end
        if (m_lock == 0 || code == m_prev) m_lock = (m_lock < 15) ? m_lock + 1 : 15;
        else m_lock = 1;
        m_prev   = code;
        e.is_err = 1'b0;
        e.cnt    = cnt;
        e.code   = code;
        e.exact  = (cnt == (code * 10 * FRAME_LEN) / 100);
        e.locked = (m_lock >= LOCK_FRAMES);
        e.t_push = $time;
        exp_q.push_back(e);
        m_frame.delete();
    endtask

    task automatic model_sample(input bit v, input logic [15:0] d, input bit s);
        exp_t e;
        if (!v) return;
        if (!m_run) begin
            if (!s) return;
            m_run = 1'b1;
            m_frame.delete();
        end else if (s && m_frame.size() != 0) begin
            e.is_err = 1'b1;
            e.cnt    = 0;
            e.code   = 0;
            e.exact  = 1'b0;
            e.locked = 1'b0;
            e.t_push = $time;
            exp_q.push_back(e);
            m_lock = 0;
            m_frame.delete();
        end
        m_frame.push_back(d);
        if (m_frame.size() == FRAME_LEN) model_frame_done();
    endtask

    // ------------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge
    // ------------------------------------------------------------------------
    always @(negedge i_clk) begin
        exp_t e;
        if (o_valid || o_err) begin
            if (exp_q.size() == 0) begin
                check("pending_expectation", exp_q.size() > 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("latency", int'($time - e.t_push), HALF_PERIOD);
                check("o_valid", int'(o_valid), e.is_err ? 0 : 1);
                check("o_err",   int'(o_err),   e.is_err ? 1 : 0);
                check("o_locked", int'(o_locked), int'(e.locked));
                if (!e.is_err) begin
                    check("o_high_cnt", int'(o_high_cnt), e.cnt);
                    check("o_code",     int'(o_code),     e.code);
                    check("o_exact",    int'(o_exact),    int'(e.exact));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step(input bit v, input logic [15:0] d, input bit s);
        i_valid = v;
        i_data  = d;
        i_sync  = s;
        @(posedge i_clk);
        if (!i_rst) model_sample(v, d, s);
        #1;
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_sync  = 1'b0;
        i_data  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        check("rst_o_valid",    int'(o_valid),    0);
        check("rst_o_code",     int'(o_code),     0);
        check("rst_o_high_cnt", int'(o_high_cnt), 0);
        check("rst_o_exact",    int'(o_exact),    0);
        check("rst_o_locked",   int'(o_locked),   0);
        check("rst_o_err",      int'(o_err),      0);
    endtask

    // mode 0: random high / random low values, shuffled
    // mode 1: generator levels, n_high x 16'h1FFF followed by zeros
    // mode 2: random highs; lows are exactly 16'sh1000 or 16'sh8000, shuffled
    // stop_at < 0 sends the whole frame, otherwise only samples 0..stop_at-1
    task automatic send_frame(input int n_high, input int mode, input bit sync_first,
                              input bit toggle, input int stop_at);
        logic [15:0] s[FRAME_LEN];
        int          n;
        n = (stop_at < 0) ? FRAME_LEN : stop_at;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (mode == 1)        s[i] = (i < n_high) ? 16'h1FFF : 16'h0000;
            else if (i < n_high)  s[i] = 16'($urandom_range(32'h7FFF, 32'h1001));
            else if (mode == 2)   s[i] = (i % 2 == 1) ? 16'h8000 : 16'h1000;
            else                  s[i] = 16'($urandom_range(36864, 0) - 32768);
        end
        if (mode != 1) begin
            for (int i = FRAME_LEN - 1; i > 0; i--) begin
                int          j;
                logic [15:0] t;
                j    = int'($urandom_range(i, 0));
                t    = s[i];
                s[i] = s[j];
                s[j] = t;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (toggle) step(1'b0, 16'($urandom), 1'($urandom));
            step(1'b1, s[i], sync_first && (i == 0));
        end
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d expectations pending",
                 exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_sync  = 1'b0;
        do_reset();

        // 50% generator stream: no lock after frame 1, lock after frame 2.
        send_frame(512, 1, 1'b1, 1'b0, -1);
        send_frame(512, 1, 1'b0, 1'b0, -1);

        // Sweep of every generator threshold, continuing the stream via wrap.
        for (int c = 0; c <= 10; c++) begin
            send_frame((c * 10 * FRAME_LEN) / 100, 0, 1'b0, 1'b0, -1);
        end

        // Decision boundaries, with lows at exactly the level and at the
        // most negative value.
        send_frame(50,  2, 1'b0, 1'b0, -1);
        send_frame(51,  2, 1'b0, 1'b0, -1);
        send_frame(971, 2, 1'b0, 1'b0, -1);
        send_frame(972, 2, 1'b0, 1'b0, -1);

        // 30% stream with i_valid low on every other cycle.
        send_frame(307, 0, 1'b0, 1'b1, -1);
        send_frame(307, 0, 1'b0, 1'b1, -1);

        // Sync reasserted at index 600, then a frame started by that sync.
        send_frame(400, 0, 1'b0, 1'b0, 600);
        send_frame(700, 0, 1'b1, 1'b0, -1);
        send_frame(700, 0, 1'b0, 1'b0, -1);

        // Sync on the final sample aborts; a sync right at the wrap does not.
        send_frame(500, 0, 1'b0, 1'b0, FRAME_LEN - 1);
        send_frame(600, 0, 1'b1, 1'b0, -1);
        send_frame(600, 0, 1'b1, 1'b0, -1);

        // Reset at index 300. Unsynced samples afterwards are ignored.
        send_frame(300, 0, 1'b0, 1'b0, 300);
        do_reset();
        send_frame(200, 0, 1'b0, 1'b0, 100);
        send_frame(820, 0, 1'b1, 1'b0, -1);

        // Random frames, each repeated once or twice to exercise lock changes.
        repeat (4) begin
            int n;
            int reps;
            bit tg;
            n    = int'($urandom_range(FRAME_LEN, 0));
            reps = int'($urandom_range(2, 1));
            tg   = 1'($urandom);
            repeat (reps) send_frame(n, 0, 1'b0, tg, -1);
        end

        // Drain the last result and confirm nothing is left outstanding.
        repeat (4) step(1'b0, 16'h0000, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
